// File: rtl/unary_dot_decoder_if.sv
// Stream/result bundle between the product-block array, the unary dot decoder
// and the downstream consumer of the binary sum.
interface unary_dot_decoder_if #(
    parameter int LANES = 4,
    parameter int WIDTH = 4,
    parameter int ACC_W = 2*WIDTH + $clog2(LANES) + 1
);
    logic             start;
    logic [LANES-1:0] lane_out;
    logic [LANES-1:0] lane_done;
    logic [ACC_W-1:0] result;
    logic             result_valid;
    logic             result_ready;
    logic             busy;
    logic             overflow;

    // master: product array plus result consumer; slave: the decoder
    modport master (
        output start, lane_out, lane_done, result_ready,
        input  result, result_valid, busy, overflow
    );

    modport slave (
        input  start, lane_out, lane_done, result_ready,
        output result, result_valid, busy, overflow
    );
endinterface

// File: rtl/unary_dot_decoder.sv
// Counts unary product pulses across all lanes until every lane reports done,
// then presents the binary sum on a valid/ready handshake.
//
//   state | meaning
//   IDLE  | waiting for start; lane inputs ignored, last result held
//   ACCUM | summing pulses of lanes that have not yet signalled done
//   HOLD  | result valid, waiting for result_ready
module unary_dot_decoder #(
    parameter int LANES = 4,
    parameter int WIDTH = 4,
    parameter int ACC_W = 2*WIDTH + $clog2(LANES) + 1
) (
    input logic                clk,
    input logic                reset_n,
    unary_dot_decoder_if.slave bus
);

    localparam int INC_W = $clog2(LANES + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] result_q;
    logic [LANES-1:0] done_seen_q;
    logic             overflow_q;

    logic [LANES-1:0] lane_act;
    logic [LANES-1:0] done_now;
    logic             all_done;
    logic [INC_W-1:0] inc;
    logic [ACC_W:0]   sum_wide;
    logic             carry;
    logic [ACC_W-1:0] acc_next;

    function automatic logic [INC_W-1:0] popcount(input logic [LANES-1:0] v);
        logic [INC_W-1:0] n;
        n = '0;
        for (int i = 0; i < LANES; i++) begin
            n = n + INC_W'(v[i]);
        end
        return n;
    endfunction

    // A pulse arriving together with its lane's done still counts.
    assign lane_act = ~done_seen_q;
    assign done_now = done_seen_q | bus.lane_done;
    assign all_done = &done_now;
    assign inc      = popcount(bus.lane_out & lane_act);
    assign sum_wide = {1'b0, acc_q} + (ACC_W+1)'(inc);
    assign carry    = sum_wide[ACC_W];
    assign acc_next = carry ? '1 : sum_wide[ACC_W-1:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start)        state_d = ACCUM;
            ACCUM:   if (all_done)         state_d = HOLD;
            HOLD:    if (bus.result_ready) state_d = IDLE;
            default:                       state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.result_valid = 1'b0;
        bus.busy         = 1'b0;
        case (state_q)
            ACCUM:   bus.busy = 1'b1;
            HOLD: begin
                bus.busy         = 1'b1;
                bus.result_valid = 1'b1;
            end
            default: ;
        endcase
    end

    // Once saturated, acc stays all-ones: any further non-zero inc carries again.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q       <= '0;
            result_q    <= '0;
            done_seen_q <= '0;
            overflow_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        acc_q       <= '0;
                        done_seen_q <= '0;
                        overflow_q  <= 1'b0;
                    end
                end
                ACCUM: begin
                    acc_q       <= acc_next;
                    done_seen_q <= done_now;
                    if (carry) begin
                        overflow_q <= 1'b1;
                    end
                    if (all_done) begin
                        result_q <= acc_next;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.result   = result_q;
    assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_unary_dot_decoder.sv
// Self-checking bench for unary_dot_decoder: directed stream scenarios plus
// randomized lane schedules scored against a per-lane pulse-count model.
module tb_unary_dot_decoder;

    localparam int LANES   = 4;
    localparam int WIDTH   = 4;
    localparam int ACC_W   = 2*WIDTH + $clog2(LANES) + 1;
    localparam int MAX_CYC = 256;
    localparam int ACC_MAX = (1 << ACC_W) - 1;

    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    unary_dot_decoder_if #(.LANES(LANES), .WIDTH(WIDTH), .ACC_W(ACC_W)) bus ();

    unary_dot_decoder #(.LANES(LANES), .WIDTH(WIDTH), .ACC_W(ACC_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Stream schedule: out_pat[c] is the pulse vector of cycle c counted from
    // the first cycle after start; rep_pat adds repeat dones after a lane's done.
    logic [LANES-1:0] out_pat [MAX_CYC];
    logic [LANES-1:0] rep_pat [MAX_CYC];
    int               done_at [LANES];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet_inputs();
        bus.start        = 1'b0;
        bus.lane_out     = '0;
        bus.lane_done    = '0;
        bus.result_ready = 1'b0;
    endtask

    task automatic clear_pattern();
        for (int c = 0; c < MAX_CYC; c++) begin
            out_pat[c] = '0;
            rep_pat[c] = '0;
        end
        for (int l = 0; l < LANES; l++) done_at[l] = 0;
    endtask

    // Each lane contributes the pulses it issued up to and including its done cycle.
    function automatic int model_sum();
        int s;
        s = 0;
        for (int l = 0; l < LANES; l++)
            for (int c = 0; c <= done_at[l]; c++)
                if (out_pat[c][l]) s++;
        return s;
    endfunction

    task automatic run_pattern(input string tag, input int hold_cycles, input bit start_in_hs);
        int ncyc;
        int raw;
        int exp_sum;
        logic exp_ovf;
        ncyc = 0;
        for (int l = 0; l < LANES; l++)
            if (done_at[l] + 1 > ncyc) ncyc = done_at[l] + 1;
        raw     = model_sum();
        exp_ovf = (raw > ACC_MAX);
        exp_sum = exp_ovf ? ACC_MAX : raw;

        quiet_inputs();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check({tag, "_busy_armed"}, 32'(bus.busy), 1);

        for (int c = 0; c < ncyc; c++) begin
            bus.lane_out = out_pat[c];
            for (int l = 0; l < LANES; l++)
                bus.lane_done[l] = (c == done_at[l]) || (c > done_at[l] && rep_pat[c][l]);
            bus.start = 1'b1 & c[0];
            tick();
            check({tag, "_valid_timing"}, 32'(bus.result_valid), 32'(c == ncyc - 1));
        end

        quiet_inputs();
        check({tag, "_result"}, 32'(bus.result), 32'(exp_sum));
        check({tag, "_overflow"}, 32'(bus.overflow), 32'(exp_ovf));

        for (int h = 0; h < hold_cycles; h++) begin
            bus.lane_out  = LANES'($urandom);
            bus.lane_done = LANES'($urandom);
            bus.start     = 1'($urandom);
            tick();
            check({tag, "_hold_result"}, 32'(bus.result), 32'(exp_sum));
            check({tag, "_hold_valid"}, 32'(bus.result_valid), 1);
        end

        quiet_inputs();
        bus.start        = start_in_hs;
        bus.result_ready = 1'b1;
        tick();
        check({tag, "_valid_dropped"}, 32'(bus.result_valid), 0);
        check({tag, "_idle_busy"}, 32'(bus.busy), 0);
        quiet_inputs();
        tick();
        check({tag, "_hs_start_ignored"}, 32'(bus.busy), 0);
        check({tag, "_result_kept"}, 32'(bus.result), 32'(exp_sum));
    endtask

    initial begin
        quiet_inputs();
        clear_pattern();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_result", 32'(bus.result), 0);
        check("rst_valid", 32'(bus.result_valid), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_overflow", 32'(bus.overflow), 0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        check("post_rst_busy", 32'(bus.busy), 0);

        // Single active lane: 6 pulses then done the next cycle.
        clear_pattern();
        for (int c = 0; c < 6; c++) out_pat[c][0] = 1'b1;
        done_at[0] = 6;
        run_pattern("one_lane", 2, 1'b0);
        check("one_lane_value", 32'(bus.result), 6);

        // Products 3*2, 5*1, empty, 15*15 with skewed dones.
        clear_pattern();
        for (int c = 0; c < 6; c++)   out_pat[c][0] = 1'b1;
        for (int c = 0; c < 5; c++)   out_pat[c][1] = 1'b1;
        for (int c = 0; c < 225; c++) out_pat[c][3] = 1'b1;
        done_at[0] = 10;
        done_at[1] = 20;
        done_at[2] = 3;
        done_at[3] = 226;
        run_pattern("products", 10, 1'b1);
        check("products_value", 32'(bus.result), 236);

        // All lanes finish together, each with a pulse on that cycle.
        clear_pattern();
        out_pat[0] = 4'b0101;
        out_pat[1] = 4'b1111;
        for (int l = 0; l < LANES; l++) done_at[l] = 1;
        run_pattern("same_cycle_done", 1, 1'b0);
        check("same_cycle_value", 32'(bus.result), 6);

        // Lane activity while IDLE must not arm or count.
        for (int i = 0; i < 5; i++) begin
            bus.lane_out  = '1;
            bus.lane_done = LANES'($urandom);
            tick();
            check("idle_ignored_busy", 32'(bus.busy), 0);
        end
        quiet_inputs();

        // Pulses after a lane's done are masked; repeat dones are harmless.
        clear_pattern();
        for (int c = 0; c < 10; c++) out_pat[c][0] = 1'b1;
        out_pat[0][1] = 1'b1;
        out_pat[4][1] = 1'b1;
        out_pat[8][1] = 1'b1;
        out_pat[5][2] = 1'b1;
        out_pat[5][3] = 1'b1;
        out_pat[7][2] = 1'b1;
        rep_pat[4][0] = 1'b1;
        rep_pat[8][2] = 1'b1;
        done_at[0] = 2;
        done_at[1] = 9;
        done_at[2] = 5;
        done_at[3] = 5;
        run_pattern("masking", 0, 1'b0);
        check("masking_value", 32'(bus.result), 8);

        // Reset in the middle of a run clears everything immediately.
        bus.start = 1'b1;
        tick();
        bus.start    = 1'b0;
        bus.lane_out = '1;
        tick();
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst_result", 32'(bus.result), 0);
        check("midrst_valid", 32'(bus.result_valid), 0);
        check("midrst_busy", 32'(bus.busy), 0);
        check("midrst_overflow", 32'(bus.overflow), 0);
        quiet_inputs();
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        check("midrst_idle", 32'(bus.busy), 0);

        clear_pattern();
        for (int c = 0; c < 9; c++) out_pat[c][2] = 1'b1;
        out_pat[3] = 4'b1011;
        done_at[0] = 4;
        done_at[1] = 3;
        done_at[2] = 12;
        done_at[3] = 7;
        run_pattern("after_reset", 3, 1'b1);

        for (int r = 0; r < 25; r++) begin
            clear_pattern();
            for (int c = 0; c < 48; c++) begin
                out_pat[c] = LANES'($urandom);
                rep_pat[c] = LANES'($urandom) & LANES'($urandom);
            end
            for (int l = 0; l < LANES; l++) done_at[l] = int'($urandom_range(0, 40));
            run_pattern("random", int'($urandom_range(0, 4)), 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
